// File: rtl/ascii2dual.sv
// Converts a CR-terminated string of ASCII decimal digits into an unsigned binary value.
// Optional build macro ASCII2DUAL_BLANK_EN: ignore leading spaces before the first digit.
module ascii2dual #(
  parameter int DUALWIDTH = 14,
  parameter int MAXDIGITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           char_in,
  input  logic                 char_valid,
  output logic                 char_ready,
  output logic [DUALWIDTH-1:0] dual,
  output logic                 finish,
  output logic                 error
);

  localparam int CW = $clog2(MAXDIGITS + 2);
  localparam int NW = DUALWIDTH + 4;
  localparam logic [NW-1:0] MAXVAL = {4'b0, {DUALWIDTH{1'b1}}};
  localparam logic [CW-1:0] CMAX   = CW'(MAXDIGITS);

  typedef enum logic [1:0] {COLLECT, MUL, DISCARD} state_t;

  state_t                state_q;
  logic [DUALWIDTH-1:0]  acc_q, dual_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            d_q;
  logic                  finish_q, error_q;

  logic                  take, is_digit, is_cr;
  logic [NW-1:0]         acc_w, nxt;

  assign char_ready = (state_q != MUL);
  assign take       = char_valid & char_ready;
  assign is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign is_cr      = (char_in == 8'h0D);

  // acc*10 + d, widened so any overflow of the result width is visible
  assign acc_w = {4'b0, acc_q};
  assign nxt   = (acc_w << 3) + (acc_w << 1) + {{DUALWIDTH{1'b0}}, d_q};

`ifdef ASCII2DUAL_BLANK_EN
  logic is_blank;
  assign is_blank = (char_in == 8'h20);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= COLLECT;
      acc_q    <= '0;
      cnt_q    <= '0;
      d_q      <= '0;
      dual_q   <= '0;
      finish_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (take) begin
            if (is_cr) begin
              finish_q <= 1'b1;
              error_q  <= (cnt_q == '0);
              if (cnt_q != '0) dual_q <= acc_q;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else if (is_digit) begin
              if (cnt_q == CMAX) begin
                state_q <= DISCARD;
              end else begin
                d_q     <= char_in[3:0];
                cnt_q   <= cnt_q + 1'b1;
                state_q <= MUL;
              end
`ifdef ASCII2DUAL_BLANK_EN
            end else if (is_blank && (cnt_q == '0)) begin
              state_q <= COLLECT;
`endif
            end else begin
              state_q <= DISCARD;
            end
          end
        end
        MUL: begin
          if (nxt > MAXVAL) begin
            state_q <= DISCARD;
          end else begin
            acc_q   <= nxt[DUALWIDTH-1:0];
            state_q <= COLLECT;
          end
        end
        DISCARD: begin
          // everything up to the terminating CR is dropped
          if (take && is_cr) begin
            finish_q <= 1'b1;
            error_q  <= 1'b1;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign dual   = dual_q;
  assign finish = finish_q;
  assign error  = error_q;

endmodule

// File: tb/tb_ascii2dual.sv
// Directed bench for ascii2dual: default-size instance (u=0) and a 7-bit/3-digit instance (u=1).
module tb_ascii2dual;
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [1:0][7:0] ci;
  logic [1:0]      cv;
  logic [1:0]      rdy, fin, err;
  logic [13:0]     dual_a;
  logic [6:0]      dual_b;
  int              asserts = 0;
  int              fails = 0;

  always #5 clock = ~clock;

  ascii2dual u_a (
    .clock(clock), .reset(reset), .char_in(ci[0]), .char_valid(cv[0]),
    .char_ready(rdy[0]), .dual(dual_a), .finish(fin[0]), .error(err[0])
  );

  ascii2dual #(.DUALWIDTH(7), .MAXDIGITS(3)) u_b (
    .clock(clock), .reset(reset), .char_in(ci[1]), .char_valid(cv[1]),
    .char_ready(rdy[1]), .dual(dual_b), .finish(fin[1]), .error(err[1])
  );

  // Sends s (plus CR when with_cr) with valid held high; returns cycles seen with ready low.
  task automatic send(input int u, input string s, input bit with_cr, output int lows);
    int n;
    lows = 0;
    n = with_cr ? s.len() + 1 : s.len();
    for (int i = 0; i < n; i++) begin
      int k = 0;
      ci[u] = (i < s.len()) ? s[i] : 8'h0D;
      cv[u] = 1'b1;
      forever begin
        @(negedge clock);
        if (rdy[u]) break;
        lows++;
        k++;
        if (k > 8) begin
          fails++;
          $display("FAIL timeout u=%0d char=%h ready stuck at %b, required 1", u, ci[u], rdy[u]);
          break;
        end
      end
      @(posedge clock);
      #1;
    end
    cv[u] = 1'b0;
  endtask

  task automatic check_end(input int u, input string name, input int dual_obs,
                           input int dual_exp, input bit err_exp);
    asserts++;
    if (fin[u] !== 1'b1) begin
      fails++;
      $display("FAIL %s finish: got %b, required 1", name, fin[u]);
    end
    asserts++;
    if (err[u] !== err_exp) begin
      fails++;
      $display("FAIL %s error: got %b, required %b", name, err[u], err_exp);
    end
    asserts++;
    if (dual_obs != dual_exp) begin
      fails++;
      $display("FAIL %s dual: got %0d, required %0d", name, dual_obs, dual_exp);
    end
  endtask

  task automatic test_reset;
    cv = '0; ci = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    asserts++;
    if ({dual_a, dual_b, fin, err, rdy} !== {14'd0, 7'd0, 2'b00, 2'b00, 2'b11}) begin
      fails++;
      $display("FAIL reset_state: got dual_a=%0d dual_b=%0d fin=%b err=%b rdy=%b, required 0 0 00 00 11",
               dual_a, dual_b, fin, err, rdy);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    int lows;
    send(0, "123", 1, lows);
    asserts++;
    if (lows != 3) begin
      fails++;
      $display("FAIL basic_ready_lows: got %0d, required 3", lows);
    end
    check_end(0, "basic_123", dual_a, 123, 1'b0);
    @(posedge clock); #1;
    asserts++;
    if (fin[0] !== 1'b0) begin
      fails++;
      $display("FAIL basic_finish_pulse: got %b, required 0", fin[0]);
    end
  endtask

  task automatic test_maxdigits;
    int lows;
    send(0, "9999", 1, lows);
    check_end(0, "max_9999", dual_a, 9999, 1'b0);
    send(0, "12345", 1, lows);
    check_end(0, "too_many_digits", dual_a, 9999, 1'b1);
    @(posedge clock); #1;
    asserts++;
    if (err[0] !== 1'b1) begin
      fails++;
      $display("FAIL error_hold: got %b, required 1", err[0]);
    end
  endtask

  task automatic test_overflow;
    int lows;
    send(1, "127", 1, lows);
    check_end(1, "small_127", int'(dual_b), 127, 1'b0);
    send(1, "128", 1, lows);
    check_end(1, "small_overflow", int'(dual_b), 127, 1'b1);
    send(1, "1000", 1, lows);
    check_end(1, "small_4digits", int'(dual_b), 127, 1'b1);
    send(1, "042", 1, lows);
    check_end(1, "small_lead0", int'(dual_b), 42, 1'b0);
  endtask

  task automatic test_illegal;
    int lows;
    send(0, "", 1, lows);
    check_end(0, "empty", dual_a, 9999, 1'b1);
    send(0, "4A7", 1, lows);
    check_end(0, "illegal_A", dual_a, 9999, 1'b1);
    send(0, "7", 1, lows);
    check_end(0, "recover_7", dual_a, 7, 1'b0);
    send(0, "0042", 1, lows);
    check_end(0, "leading_zeros", dual_a, 42, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lows;
    send(0, "", 1, lows);
    send(0, "", 1, lows);
    check_end(0, "b2b_cr", dual_a, 42, 1'b1);
    send(0, "3", 1, lows);
    check_end(0, "b2b_after", dual_a, 3, 1'b0);
  endtask

  task automatic test_midreset;
    int lows;
    bit seen = 0;
    send(0, "56", 0, lows);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (fin[0]) seen = 1;
      @(posedge clock); #1;
    end
    asserts++;
    if (seen || dual_a !== 14'd0) begin
      fails++;
      $display("FAIL midreset_drop: got finish_seen=%b dual=%0d, required 0 0", seen, dual_a);
    end
    send(0, "8", 1, lows);
    check_end(0, "midreset_8", dual_a, 8, 1'b0);
  endtask

  task automatic test_blank;
    int lows;
    send(0, "  42", 1, lows);
`ifdef ASCII2DUAL_BLANK_EN
    check_end(0, "blank_lead", dual_a, 42, 1'b0);
    send(0, "4 2", 1, lows);
    check_end(0, "blank_inner", dual_a, 42, 1'b1);
`else
    check_end(0, "blank_lead", dual_a, 8, 1'b1);
    send(0, "4 2", 1, lows);
    check_end(0, "blank_inner", dual_a, 8, 1'b1);
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_maxdigits;
    test_overflow;
    test_illegal;
    test_back_to_back;
    test_midreset;
    test_blank;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
